// File: rtl/led_sched_pkg.sv
// led_sched_pkg: shared FSM state encoding, default widths and index-width helper for the LED blink scheduler
package led_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  localparam int CNT_W = 10;
  localparam int BLK_W = 4;
  localparam int GAP_CYC = 2;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/led_rr_arbiter.sv
// led_rr_arbiter: round-robin winner select with registered pointer; fixed lowest-index priority when LED_SCHED_FIXED_PRIO_EN is defined
module led_rr_arbiter
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W = idx_w(NUM_REQ)
) (
  input  logic               clk_in1,
  input  logic               rst_in1,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [IDX_W-1:0]   win,
  output logic               vld
);
  logic [IDX_W-1:0] start;
  int idx;
`ifdef LED_SCHED_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDX_W-1:0] ptr;
  // move the search start just past every granted winner, aborted or not
  always_ff @(posedge clk_in1) begin
    if (rst_in1) ptr <= '0;
    else if (adv && vld) ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end
  assign start = ptr;
`endif
  // scan downward so the requester nearest to start is the last one written
  always_comb begin
    win = '0;
    vld = 1'b0;
    idx = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[IDX_W'(idx)]) begin
        win = IDX_W'(idx);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/led_blink_sched.sv
// led_blink_sched: shares one LED among requesters, blinking each winner's latched pattern; LED_SCHED_FIXED_PRIO_EN selects fixed priority
module led_blink_sched
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = led_sched_pkg::CNT_W,
  parameter int BLK_W = led_sched_pkg::BLK_W,
  parameter int GAP_CYC = led_sched_pkg::GAP_CYC
) (
  input  logic                     clk_in1,
  input  logic                     rst_in1,
  input  logic [NUM_REQ-1:0]       req_in,
  input  logic [NUM_REQ*CNT_W-1:0] half_period_in,
  input  logic [NUM_REQ*BLK_W-1:0] blinks_in,
  output logic [NUM_REQ-1:0]       grant_out,
  output logic [NUM_REQ-1:0]       done_out,
  output logic                     busy_out,
  output logic                     led_out1
);
  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int GAP_W = idx_w(GAP_CYC);
  state_t state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic led_n, vld, done, hold, wrap;
  logic [CNT_W-1:0] cnt, cnt_n, hp, hp_n, hp_sel;
  logic [BLK_W-1:0] rem, rem_n, bl_sel;
  logic [GAP_W-1:0] gcnt, gcnt_n;
  logic [IDX_W-1:0] win, win_r, win_n;

  led_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk_in1 (clk_in1),
    .rst_in1 (rst_in1),
    .req     (req_in),
    .adv     (state == IDLE),
    .win     (win),
    .vld     (vld)
  );

  assign hp_sel = half_period_in[int'(win) * CNT_W +: CNT_W];
  assign bl_sel = blinks_in[int'(win) * BLK_W +: BLK_W];
  assign hold = req_in[win_r];
  assign wrap = cnt == hp - 1'b1;
  assign busy_out = state != IDLE;
  assign done_out = done ? grant_out : '0;

  // next state: grant in IDLE, phase/blink bookkeeping in RUN, fixed-length GAP
  always_comb begin
    state_n = state;
    grant_n = grant_out;
    led_n = led_out1;
    cnt_n = cnt;
    hp_n = hp;
    rem_n = rem;
    gcnt_n = gcnt;
    win_n = win_r;
    done = 1'b0;
    if (state == IDLE) begin
      if (vld) begin
        state_n = RUN;
        grant_n = '0;
        grant_n[win] = 1'b1;
        win_n = win;
        hp_n = (hp_sel == '0) ? CNT_W'(1) : hp_sel;
        rem_n = bl_sel;
        led_n = bl_sel != '0;
        cnt_n = '0;
      end
    end else if (state == RUN) begin
      if (!hold || rem == '0 || (wrap && !led_out1 && rem == BLK_W'(1))) begin
        done = hold;
        state_n = GAP;
        grant_n = '0;
        led_n = 1'b0;
        cnt_n = '0;
        rem_n = '0;
        gcnt_n = '0;
      end else if (wrap) begin
        cnt_n = '0;
        led_n = !led_out1;
        rem_n = led_out1 ? rem : rem - 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end else begin
      state_n = (int'(gcnt) >= GAP_CYC - 1) ? IDLE : GAP;
      gcnt_n = gcnt + 1'b1;
    end
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk_in1) begin
    if (rst_in1) begin
      state <= IDLE;
      grant_out <= '0;
      led_out1 <= 1'b0;
      cnt <= '0;
      hp <= '0;
      rem <= '0;
      gcnt <= '0;
      win_r <= '0;
    end else begin
      state <= state_n;
      grant_out <= grant_n;
      led_out1 <= led_n;
      cnt <= cnt_n;
      hp <= hp_n;
      rem <= rem_n;
      gcnt <= gcnt_n;
      win_r <= win_n;
    end
  end
endmodule
